decode_seq: RTL and testbench

DECODE_SEQ -- requirements
Module: decode_seq

---
 rtl/cpu_pkg.sv | 56 +++++
 rtl/alu.sv | 32 +++
 rtl/decode_seq.sv | 136 +++++++++++++
 tb/tb_decode_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the decode/sequence block: opcode and FSM state
// enums, instruction field positions, and an instruction legality helper.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SLL  = 4'd6,
    OP_SRL  = 4'd7,
    OP_MOV  = 4'd8,
    OP_LI   = 4'd9,
    OP_HALT = 4'd15
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE,
    S_HALT
  } state_e;

  // Field positions inside the instruction word.
  localparam int FIELD_W = 4;
  localparam int IMM_W   = 8;
  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 8;
  localparam int RS_LSB  = 4;
  localparam int RT_LSB  = 0;
  localparam int IMM_LSB = 0;

  // An instruction is legal when its opcode is defined and every register
  // field that the opcode actually uses addresses an existing register.
  function automatic logic instr_legal(input logic [15:0] w, input int nregs);
    logic [FIELD_W-1:0] op;
    logic               rd_ok;
    logic               rs_ok;
    logic               rt_ok;
    op    = w[OPC_LSB +: FIELD_W];
    rd_ok = int'(w[RD_LSB +: FIELD_W]) < nregs;
    rs_ok = int'(w[RS_LSB +: FIELD_W]) < nregs;
    rt_ok = int'(w[RT_LSB +: FIELD_W]) < nregs;
    case (op)
      OP_NOP, OP_HALT:                                      return 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL: return rd_ok && rs_ok && rt_ok;
      OP_MOV:                                               return rd_ok && rs_ok;
      OP_LI:                                                return rd_ok;
      default:                                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU for decode_seq.
//   op     : opcode (cpu_pkg::opcode_e values)
//   a, b   : operands (rs and rt register data)
//   result : ADD/SUB wrap, bitwise logic ops, SLL/SRL by b[2:0] with zero
//            fill, MOV passes a; anything else yields zero.
module alu
  import cpu_pkg::*;
#(
  parameter int width = 8
) (
  input  logic [3:0]       op,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = a << b[2:0];
      OP_SRL:  result = a >> b[2:0];
      OP_MOV:  result = a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/decode_seq.sv
// Multi-cycle instruction decoder/sequencer driving an external register file.
//   clk, rst_n               : clock, asynchronous active-low reset
//   instr_valid/instr_ready  : instruction handshake (ready only in IDLE)
//   instr                    : instruction word, latched on accept
//   rf_read, rf_write        : register-file strobes
//   rf_rs_addr/rt_addr/rd_addr : addresses, driven from the latched instruction
//   rf_rd_in                 : write data (result register)
//   rf_rs_out, rf_rt_out     : registered read data, valid the cycle after rf_read
//   done                     : one-cycle retire pulse
//   halted                   : HALT executed (cleared only by reset)
//   err                      : sticky illegal-instruction flag
module decode_seq
  import cpu_pkg::*;
#(
  parameter  int num_regs    = 12,
  parameter  int reg_width   = 8,
  parameter  int instr_width = 16,
  localparam int AW          = $clog2(num_regs)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [instr_width-1:0] instr,
  output logic                   rf_read,
  output logic                   rf_write,
  output logic [AW-1:0]          rf_rs_addr,
  output logic [AW-1:0]          rf_rt_addr,
  output logic [AW-1:0]          rf_rd_addr,
  output logic [reg_width-1:0]   rf_rd_in,
  input  logic [reg_width-1:0]   rf_rs_out,
  input  logic [reg_width-1:0]   rf_rt_out,
  output logic                   done,
  output logic                   halted,
  output logic                   err
);

  state_e                 state;
  logic [instr_width-1:0] instr_q;
  logic [reg_width-1:0]   result_q;
  logic [reg_width-1:0]   alu_y;
  logic [FIELD_W-1:0]     op_in;
  logic [FIELD_W-1:0]     op_q;
  logic [FIELD_W-1:0]     rd_f;
  logic [FIELD_W-1:0]     rs_f;
  logic [FIELD_W-1:0]     rt_f;
  logic                   legal_in;

  assign op_in    = instr[OPC_LSB +: FIELD_W];
  assign legal_in = instr_legal(instr[15:0], num_regs);

  assign op_q = instr_q[OPC_LSB +: FIELD_W];
  assign rd_f = instr_q[RD_LSB +: FIELD_W];
  assign rs_f = instr_q[RS_LSB +: FIELD_W];
  assign rt_f = instr_q[RT_LSB +: FIELD_W];

  // Addresses come straight from the latched instruction, so they hold
  // steady for the whole instruction and are zero while in reset.
  assign rf_rs_addr = rs_f[AW-1:0];
  assign rf_rt_addr = rt_f[AW-1:0];
  assign rf_rd_addr = rd_f[AW-1:0];
  assign rf_rd_in   = result_q;

  alu #(.width(reg_width)) u_alu (
    .op     (op_q),
    .a      (rf_rs_out),
    .b      (rf_rt_out),
    .result (alu_y)
  );

  // Strobes are set on the edge entering the state they belong to, so
  // rf_read is high throughout READ and rf_write/done throughout WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      instr_q     <= '0;
      result_q    <= '0;
      instr_ready <= 1'b1;
      rf_read     <= 1'b0;
      rf_write    <= 1'b0;
      done        <= 1'b0;
      halted      <= 1'b0;
      err         <= 1'b0;
    end else begin
      rf_read  <= 1'b0;
      rf_write <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (instr_valid && instr_ready) begin
            instr_q <= instr;
            if (!legal_in) begin
              err  <= 1'b1;
              done <= 1'b1;
            end else begin
              case (op_in)
                OP_NOP: done <= 1'b1;
                OP_LI: begin
                  state       <= S_EXEC;
                  instr_ready <= 1'b0;
                end
                OP_HALT: begin
                  state       <= S_HALT;
                  instr_ready <= 1'b0;
                  halted      <= 1'b1;
                end
                default: begin
                  state       <= S_READ;
                  instr_ready <= 1'b0;
                  rf_read     <= 1'b1;
                end
              endcase
            end
          end
        end
        S_READ: state <= S_EXEC;
        S_EXEC: begin
          result_q <= (op_q == OP_LI) ? reg_width'(instr_q[IMM_LSB +: IMM_W]) : alu_y;
          rf_write <= 1'b1;
          done     <= 1'b1;
          state    <= S_WRITE;
        end
        S_WRITE: begin
          instr_ready <= 1'b1;
          state       <= S_IDLE;
        end
        S_HALT: state <= S_HALT;
        default: begin
          instr_ready <= 1'b1;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decode_seq.sv
// Self-checking bench for decode_seq: register-file responder plus a
// behavioural instruction model with its own shadow register file.
module tb_decode_seq;

  localparam int NREGS = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic        rf_read, rf_write;
  logic [3:0]  rf_rs_addr, rf_rt_addr, rf_rd_addr;
  logic [7:0]  rf_rd_in;
  logic [7:0]  rf_rs_out = '0;
  logic [7:0]  rf_rt_out = '0;
  logic        done, halted, err;

  decode_seq #(.num_regs(NREGS), .reg_width(8), .instr_width(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rf_read     (rf_read),
    .rf_write    (rf_write),
    .rf_rs_addr  (rf_rs_addr),
    .rf_rt_addr  (rf_rt_addr),
    .rf_rd_addr  (rf_rd_addr),
    .rf_rd_in    (rf_rd_in),
    .rf_rs_out   (rf_rs_out),
    .rf_rt_out   (rf_rt_out),
    .done        (done),
    .halted      (halted),
    .err         (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem    [16];
  int         ref_rf [16];
  logic       ref_err = 1'b0;
  logic       pl_en = 1'b0;
  logic [3:0] pl_addr = '0;
  logic [7:0] pl_data = '0;
  int         last_wr;

  // Register file: registered read data, write on rf_write, bench preload port.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (rf_write) mem[rf_rd_addr] <= rf_rd_in;
    if (rf_read) begin
      rf_rs_out <= mem[rf_rs_addr];
      rf_rt_out <= mem[rf_rt_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] status();
    return {instr_ready, rf_read, rf_write, done, halted, err};
  endfunction

  task automatic preload(input int a, input int d);
    @(negedge clk);
    pl_en   = 1'b1;
    pl_addr = 4'(a);
    pl_data = 8'(d);
    ref_rf[a] = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Issue one instruction and check every cycle until the block is ready again.
  // kind: 0 retire-in-IDLE (NOP/illegal), 1 register op, 2 LI, 3 HALT.
  task automatic run_instr(input logic [15:0] w);
    int op, rd, rs, rt, imm, a, b, sh, res, kind, n, kwr;
    logic legal;
    logic [5:0] e;
    op  = int'(w[15:12]);
    rd  = int'(w[11:8]);
    rs  = int'(w[7:4]);
    rt  = int'(w[3:0]);
    imm = int'(w[7:0]);
    if (op >= 1 && op <= 7)   legal = (rd < NREGS) && (rs < NREGS) && (rt < NREGS);
    else if (op == 8)         legal = (rd < NREGS) && (rs < NREGS);
    else if (op == 9)         legal = (rd < NREGS);
    else                      legal = (op == 0) || (op == 15);
    a  = ref_rf[rs];
    b  = ref_rf[rt];
    sh = b % 8;
    case (op)
      1:       res = (a + b) % 256;
      2:       res = (a - b + 256) % 256;
      3:       res = a & b;
      4:       res = a | b;
      5:       res = a ^ b;
      6:       res = (a * (1 << sh)) % 256;
      7:       res = a / (1 << sh);
      8:       res = a;
      9:       res = imm;
      default: res = 0;
    endcase
    if (!legal || op == 0) kind = 0;
    else if (op == 9)      kind = 2;
    else if (op == 15)     kind = 3;
    else                   kind = 1;
    n   = (kind == 0) ? 1 : (kind == 2) ? 3 : 4;
    kwr = (kind == 1) ? 3 : (kind == 2) ? 2 : 0;
    if (!legal) ref_err = 1'b1;

    @(negedge clk);
    instr_valid = 1'b1;
    instr       = w;
    check_eq($sformatf("ready_before_%h", w), instr_ready, 1);
    @(posedge clk);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      // keep offering junk while busy; it must be ignored
      instr       = 16'($urandom);
      instr_valid = (k < n);
      e[5] = (kind == 0) || (k == n && kind != 3);
      e[4] = (kind == 1) && (k == 1);
      e[3] = (k == kwr);
      e[2] = (k == kwr) || (kind == 0);
      e[1] = (kind == 3);
      e[0] = ref_err;
      check_eq($sformatf("status_%h_k%0d", w, k), status(), e);
      if (kind == 1 && k == 1) begin
        check_eq($sformatf("rs_addr_%h", w), rf_rs_addr, rs);
        check_eq($sformatf("rt_addr_%h", w), rf_rt_addr, rt);
      end
      if (k == kwr) begin
        check_eq($sformatf("rd_addr_%h", w), rf_rd_addr, rd);
        check_eq($sformatf("rd_in_%h", w), rf_rd_in, res);
        last_wr = int'(rf_rd_in);
      end
    end
    if (kwr != 0) ref_rf[rd] = res;
  endtask

  initial begin
    int acc;
    logic [15:0] w;
    int op, rd, rs, rt;

    // Reset state
    @(negedge clk);
    check_eq("reset_status", status(), 6'b100000);
    check_eq("reset_addrs", {rf_rs_addr, rf_rt_addr, rf_rd_addr}, 0);
    check_eq("reset_rd_in", rf_rd_in, 0);

    for (int i = 0; i < 16; i++) preload(i, int'($urandom_range(0, 255)));
    preload(1, 8'h05);
    preload(2, 8'h03);
    preload(6, 8'h81);
    preload(7, 8'h01);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic cases
    run_instr(16'h1412);  check_eq("add_r4", last_wr, 8'h08);
    run_instr(16'h2521);  check_eq("sub_wrap", last_wr, 8'hFE);
    run_instr(16'h6867);  check_eq("sll", last_wr, 8'h02);
    run_instr(16'h90A5);  check_eq("li_r0", last_wr, 8'hA5);
    run_instr(16'h8A40);  check_eq("mov_r10", last_wr, 8'h08);

    // Back-to-back: valid held high, one accept every 4 cycles
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = 16'h1412;
    acc         = 0;
    for (int c = 0; c < 12; c++) begin
      check_eq($sformatf("b2b_ready_c%0d", c), instr_ready, (c % 4) == 0);
      if (instr_ready) acc++;
      @(posedge clk);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    check_eq("b2b_accepts", acc, 3);
    ref_rf[4] = (ref_rf[1] + ref_rf[2]) % 256;

    // Illegal opcode, out-of-range rd, out-of-range rs, then normal execution
    run_instr(16'hC123);
    run_instr(16'h1D12);
    run_instr(16'h83C0);
    run_instr(16'h3312);  check_eq("and_after_err", last_wr, 8'h01);
    check_eq("err_sticky", err, 1);

    // Randomized mix
    for (int i = 0; i < 80; i++) begin
      op = int'($urandom_range(0, 14));
      rd = ($urandom_range(0, 9) == 0) ? int'($urandom_range(12, 15)) : int'($urandom_range(0, 11));
      rs = ($urandom_range(0, 9) == 0) ? int'($urandom_range(12, 15)) : int'($urandom_range(0, 11));
      rt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(12, 15)) : int'($urandom_range(0, 11));
      w  = 16'((op << 12) | (rd << 8) | (rs << 4) | rt);
      run_instr(w);
    end

    // Reset asserted during EXEC of AND r3,r1,r2
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = 16'h3312;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_reset_status", status(), 6'b100000);
    check_eq("async_reset_addrs", {rf_rs_addr, rf_rt_addr, rf_rd_addr}, 0);
    check_eq("async_reset_rd_in", rf_rd_in, 0);
    ref_err = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq($sformatf("in_reset_status_c%0d", c), status(), 6'b100000);
    end
    rst_n = 1'b1;
    // r3 must still hold its pre-reset value
    run_instr(16'h8B30);
    check_eq("r3_untouched", last_wr, 8'(ref_rf[3]));

    // HALT: stays halted, never ready, until reset
    run_instr(16'hF000);
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = 16'h1412;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq($sformatf("halt_hold_c%0d", c), status(), 6'b000010);
    end
    instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("halt_reset_status", status(), 6'b100000);
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(16'h9177);  check_eq("li_after_halt", last_wr, 8'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
